count_monitor: RTL
==================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The block SHALL have one parameter: PERIOD_W, default 8, bit width of the period field and period counter.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 count_in  input  4  counter value from the upstream step counter, one sample per cycle.
REQ-005 ctrl_in  input  1  step select driven to the upstream counter this cycle (1 = step 2, 0 = step 1).
REQ-006 clr  input  1  synchronous clear of error, overflow and statistics.
REQ-007 evt_ready  input  1  consumer accepts the wrap event when high with evt_valid.
REQ-008 evt_valid  output  1  wrap event pending.
REQ-009 evt_period  output  PERIOD_W  cycles between consecutive wraps.
REQ-010 evt_wraps  output  8  total wraps observed, including this event.
REQ-011 err  output  1  sticky step-violation flag.
REQ-012 ovf  output  1  sticky event-dropped flag.

Function
REQ-013 The block SHALL implement FSM states IDLE, TRACK, ERROR.
REQ-014 IDLE: capture count_in/ctrl_in into prev_count/prev_ctrl, clear the period counter, go to TRACK next cycle.
REQ-015 TRACK: delta = (count_in - prev_count) mod 16; expected = 2 if prev_ctrl else 1; prev_count/prev_ctrl update every cycle.
REQ-016 TRACK, count_in == 0 and delta != expected: upstream resync; clear the period counter, no error, stay TRACK.
REQ-017 TRACK, delta != expected and not REQ-016: set err, go to ERROR.
REQ-018 Wrap = TRACK, delta == expected and count_in < prev_count (unsigned).
REQ-019 Period counter SHALL increment by 1 per non-wrap TRACK cycle and saturate at 2^PERIOD_W-1.
REQ-020 On wrap, event period = period counter + 1 (saturating); the counter then clears to 0.
REQ-021 On wrap, the wrap count SHALL increment, saturating at 255.
REQ-022 Events SHALL appear registered: evt_valid high the cycle after the edge on which the wrap sample is taken.
REQ-023 While evt_valid=1 and evt_ready=0, evt_period/evt_wraps SHALL hold stable.
REQ-024 evt_valid=1 and evt_ready=1 with no new wrap: evt_valid clears next cycle.
REQ-025 New wrap while evt_valid=1 and evt_ready=0: the new event is dropped, the pending event kept, ovf set.
REQ-026 New wrap while evt_valid=1 and evt_ready=1: the old event is accepted, the new one loaded, evt_valid stays 1, no ovf.
REQ-027 ERROR: no wraps or events are generated; a pending event stays until accepted; exit only via clr.
REQ-028 clr=1 in any state: err, ovf, wrap count clear; FSM goes to IDLE; a pending event is discarded (evt_valid=0).

Reset
REQ-029 rst=0 SHALL immediately force FSM=IDLE, evt_valid=0, evt_period=0, evt_wraps=0, err=0, ovf=0, and clear prev_count, prev_ctrl, the period counter and the wrap count.
REQ-030 Reset asserted mid-operation SHALL discard any pending event; after release the block SHALL restart from IDLE.

Configuration
REQ-031 Macro COUNT_MONITOR_STATS_EN defined: the wrap counter is present and evt_wraps behaves per REQ-010/021.
REQ-032 Macro COUNT_MONITOR_STATS_EN undefined: the wrap counter is absent and evt_wraps is tied to 0; all other behaviour is unchanged.

Verification
REQ-033 ctrl_in=0, count_in 0,1,...,15,0 from IDLE -> one event, evt_period=16, evt_wraps=1, err=0.
REQ-034 ctrl_in=1, count_in 1,3,...,15,1 -> evt_period=8 on the 15->1 wrap; repeat -> evt_wraps=2.
REQ-035 evt_ready=0, two wraps 16 cycles apart -> first event held unchanged, ovf=1; with evt_ready=1 on the second wrap cycle instead -> second event loaded, ovf=0.
REQ-036 ctrl_in=0, count_in 4 then 7 -> err=1, FSM=ERROR, no further events; clr pulse -> err=0, FSM=IDLE.
REQ-037 count_in 5,6,0,1 with ctrl_in=0 -> no error, period counter cleared at 0; rst=0 during a pending event -> evt_valid=0 immediately.
REQ-038 Run REQ-033 with COUNT_MONITOR_STATS_EN undefined -> evt_period=16, evt_wraps=0.

Source files
------------

// File: rtl/count_monitor.sv
// Monitors an upstream 1/2-step counter: flags step violations, measures wrap periods, emits wrap events.
// Optional macro COUNT_MONITOR_STATS_EN adds the saturating wrap counter reported on evt_wraps.
module count_monitor #(
   parameter int unsigned PERIOD_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          count_in,
   input  logic                ctrl_in,
   input  logic                clr,
   input  logic                evt_ready,
   output logic                evt_valid,
   output logic [PERIOD_W-1:0] evt_period,
   output logic [7:0]          evt_wraps,
   output logic                err,
   output logic                ovf
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   localparam logic [PERIOD_W-1:0] PERIOD_MAX  = {PERIOD_W{1'b1}};
   localparam logic [PERIOD_W-1:0] PERIOD_ZERO = {PERIOD_W{1'b0}};

   state_t              state_q, state_d;
   logic [3:0]          prev_count_q, prev_count_d;
   logic                prev_ctrl_q, prev_ctrl_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                evt_valid_q, evt_valid_d;
   logic [PERIOD_W-1:0] evt_period_q, evt_period_d;
   logic [7:0]          evt_wraps_q, evt_wraps_d;
   logic                err_q, err_d;
   logic                ovf_q, ovf_d;

   logic [3:0]          delta_s;
   logic [3:0]          expected_s;
   logic                step_ok_s;
   logic                wrap_s;
   logic [PERIOD_W-1:0] period_inc_s;
   logic [7:0]          wraps_inc_s;

   // Step check against the step size requested on the previous sample.
   always_comb begin
      delta_s      = count_in - prev_count_q;
      expected_s   = prev_ctrl_q ? 4'd2 : 4'd1;
      step_ok_s    = (delta_s == expected_s);
      wrap_s       = (state_q == ST_TRACK) && step_ok_s && (count_in < prev_count_q);
      period_inc_s = (period_q == PERIOD_MAX) ? PERIOD_MAX : (period_q + PERIOD_W'(1));
   end

`ifdef COUNT_MONITOR_STATS_EN
   logic [7:0] wraps_q, wraps_d;

   // Saturating wrap count, cleared by clr.
   always_comb begin
      wraps_inc_s = (wraps_q == 8'd255) ? 8'd255 : (wraps_q + 8'd1);
      if (clr) begin
         wraps_d = 8'd0;
      end else if (wrap_s) begin
         wraps_d = wraps_inc_s;
      end else begin
         wraps_d = wraps_q;
      end
   end

   // Wrap count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wraps_q <= 8'd0;
      end else begin
         wraps_q <= wraps_d;
      end
   end
`else
   assign wraps_inc_s = 8'd0;
`endif

   // Next-state logic; a pending event is accepted whenever evt_ready is high.
   always_comb begin
      state_d      = state_q;
      prev_count_d = prev_count_q;
      prev_ctrl_d  = prev_ctrl_q;
      period_d     = period_q;
      evt_valid_d  = evt_valid_q & ~evt_ready;
      evt_period_d = evt_period_q;
      evt_wraps_d  = evt_wraps_q;
      err_d        = err_q;
      ovf_d        = ovf_q;
      if (clr) begin
         state_d     = ST_IDLE;
         err_d       = 1'b0;
         ovf_d       = 1'b0;
         evt_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               prev_count_d = count_in;
               prev_ctrl_d  = ctrl_in;
               period_d     = PERIOD_ZERO;
               state_d      = ST_TRACK;
            end
            ST_TRACK: begin
               prev_count_d = count_in;
               prev_ctrl_d  = ctrl_in;
               if (step_ok_s) begin
                  if (wrap_s) begin
                     period_d = PERIOD_ZERO;
                     // A slot is free if empty or being accepted this same cycle.
                     if (!evt_valid_q || evt_ready) begin
                        evt_valid_d  = 1'b1;
                        evt_period_d = period_inc_s;
                        evt_wraps_d  = wraps_inc_s;
                     end else begin
                        ovf_d = 1'b1;
                     end
                  end else begin
                     period_d = period_inc_s;
                  end
               end else if (count_in == 4'd0) begin
                  period_d = PERIOD_ZERO;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end
            end
            ST_ERROR: begin
               state_d = ST_ERROR;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         prev_count_q <= 4'd0;
         prev_ctrl_q  <= 1'b0;
         period_q     <= PERIOD_ZERO;
         evt_valid_q  <= 1'b0;
         evt_period_q <= PERIOD_ZERO;
         evt_wraps_q  <= 8'd0;
         err_q        <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_count_q <= prev_count_d;
         prev_ctrl_q  <= prev_ctrl_d;
         period_q     <= period_d;
         evt_valid_q  <= evt_valid_d;
         evt_period_q <= evt_period_d;
         evt_wraps_q  <= evt_wraps_d;
         err_q        <= err_d;
         ovf_q        <= ovf_d;
      end
   end

   assign evt_valid  = evt_valid_q;
   assign evt_period = evt_period_q;
   assign evt_wraps  = evt_wraps_q;
   assign err        = err_q;
   assign ovf        = ovf_q;

endmodule
